// File: rtl/uncached_data_responder_pkg.sv
// Shared LSU definitions used by the uncached data responder:
// FSM states, LSU access size encoding and the latched request entry.
package uncached_data_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } ud_state_e;

    typedef enum logic [1:0] {
        s_byte = 2'd0,
        s_half = 2'd1,
        s_word = 2'd2
    } size_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write_en;
        logic [31:0] data;
        logic [3:0]  strobe;
        size_e       size;
    } uncached_req_entry_t;

    // The reserved size code 3 is issued on the bus as a full word.
    function automatic size_e norm_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return s_byte;
            2'd1:    return s_half;
            default: return s_word;
        endcase
    endfunction

endpackage

// File: rtl/uncached_data_responder_if.sv
// LSU DataReq/DataResp channel plus the SRAM-like external bus, as seen
// by the responder (slave) and by whoever drives it (master).
interface uncached_data_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write_en;
    logic [31:0] req_data;
    logic [3:0]  req_strobe;
    logic [1:0]  req_size;

    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ready;

    logic        sram_req;
    logic        sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wstrb;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    modport slave (
        input  req_valid, req_addr, req_write_en, req_data, req_strobe, req_size,
        input  resp_ready,
        input  sram_addr_ok, sram_data_ok, sram_rdata,
        output req_ready,
        output resp_valid, resp_data,
        output sram_req, sram_wr, sram_size, sram_addr, sram_wdata, sram_wstrb
    );

    modport master (
        output req_valid, req_addr, req_write_en, req_data, req_strobe, req_size,
        output resp_ready,
        output sram_addr_ok, sram_data_ok, sram_rdata,
        input  req_ready,
        input  resp_valid, resp_data,
        input  sram_req, sram_wr, sram_size, sram_addr, sram_wdata, sram_wstrb
    );

endinterface

// File: rtl/uncached_data_responder.sv
// Memory-side endpoint of the LSU uncached data channel: one transaction at a
// time, issued as a single SRAM-like bus access, load data returned on DataResp.
module uncached_data_responder
    import uncached_data_responder_pkg::*;
#(
    parameter bit WRITE_ACK = 1'b0
) (
    input  logic                          clk,
    input  logic                          resetn,
    uncached_data_responder_if.slave      bus
);

    // state | meaning
    // IDLE  | ready for a new DataReq
    // ADDR  | bus request driven, waiting for addr_ok
    // DATA  | address accepted, waiting for data_ok
    // RESP  | response beat held until resp_ready

    ud_state_e           state_q;
    uncached_req_entry_t req_q;
    logic [31:0]         resp_q;
    logic                bus_done_d;

    // data_ok only counts once the address has been (or is being) accepted.
    assign bus_done_d = ((state_q == ADDR) && bus.sram_addr_ok && bus.sram_data_ok) ||
                        ((state_q == DATA) && bus.sram_data_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            req_q   <= '0;
            resp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q.addr     <= bus.req_addr;
                        req_q.write_en <= bus.req_write_en;
                        req_q.data     <= bus.req_data;
                        req_q.strobe   <= bus.req_strobe;
                        req_q.size     <= norm_size(bus.req_size);
                        state_q        <= ADDR;
                    end
                end
                ADDR, DATA: begin
                    if (bus_done_d) begin
                        if (!req_q.write_en) begin
                            resp_q  <= bus.sram_rdata;
                            state_q <= RESP;
                        end else if (WRITE_ACK) begin
                            resp_q  <= '0;
                            state_q <= RESP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if ((state_q == ADDR) && bus.sram_addr_ok) begin
                        state_q <= DATA;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = resp_q;

    assign bus.sram_req   = (state_q == ADDR);
    assign bus.sram_wr    = req_q.write_en;
    assign bus.sram_size  = req_q.size;
    assign bus.sram_addr  = req_q.addr;
    assign bus.sram_wdata = req_q.data;
    assign bus.sram_wstrb = req_q.strobe;

endmodule

// File: tb/tb_uncached_data_responder.sv
// Directed bench for uncached_data_responder; two instances cover WRITE_ACK 0 and 1.
module tb_uncached_data_responder;

    logic clk;
    logic resetn;
    logic sel;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_write_en;
    logic [31:0] req_data;
    logic [3:0]  req_strobe;
    logic [1:0]  req_size;
    logic        resp_ready;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    int total;
    int bad;

    uncached_data_responder_if if0 ();
    uncached_data_responder_if if1 ();

    assign if0.req_valid    = req_valid & ~sel;
    assign if1.req_valid    = req_valid & sel;
    assign if0.req_addr     = req_addr;
    assign if1.req_addr     = req_addr;
    assign if0.req_write_en = req_write_en;
    assign if1.req_write_en = req_write_en;
    assign if0.req_data     = req_data;
    assign if1.req_data     = req_data;
    assign if0.req_strobe   = req_strobe;
    assign if1.req_strobe   = req_strobe;
    assign if0.req_size     = req_size;
    assign if1.req_size     = req_size;
    assign if0.resp_ready   = resp_ready;
    assign if1.resp_ready   = resp_ready;
    assign if0.sram_addr_ok = sram_addr_ok;
    assign if1.sram_addr_ok = sram_addr_ok;
    assign if0.sram_data_ok = sram_data_ok;
    assign if1.sram_data_ok = sram_data_ok;
    assign if0.sram_rdata   = sram_rdata;
    assign if1.sram_rdata   = sram_rdata;

    uncached_data_responder #(.WRITE_ACK(1'b0)) u_dut0 (.clk(clk), .resetn(resetn), .bus(if0));
    uncached_data_responder #(.WRITE_ACK(1'b1)) u_dut1 (.clk(clk), .resetn(resetn), .bus(if1));

    logic        o_req_ready, o_resp_valid, o_sram_req, o_sram_wr;
    logic [31:0] o_resp_data, o_sram_addr, o_sram_wdata;
    logic [1:0]  o_sram_size;
    logic [3:0]  o_sram_wstrb;

    assign o_req_ready  = sel ? if1.req_ready  : if0.req_ready;
    assign o_resp_valid = sel ? if1.resp_valid : if0.resp_valid;
    assign o_resp_data  = sel ? if1.resp_data  : if0.resp_data;
    assign o_sram_req   = sel ? if1.sram_req   : if0.sram_req;
    assign o_sram_wr    = sel ? if1.sram_wr    : if0.sram_wr;
    assign o_sram_size  = sel ? if1.sram_size  : if0.sram_size;
    assign o_sram_addr  = sel ? if1.sram_addr  : if0.sram_addr;
    assign o_sram_wdata = sel ? if1.sram_wdata : if0.sram_wdata;
    assign o_sram_wstrb = sel ? if1.sram_wstrb : if0.sram_wstrb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"},  {31'd0, o_req_ready},  32'd1);
        chk({tag, ".resp_valid"}, {31'd0, o_resp_valid}, 32'd0);
        chk({tag, ".resp_data"},  o_resp_data,           32'd0);
        chk({tag, ".sram_req"},   {31'd0, o_sram_req},   32'd0);
        chk({tag, ".sram_wr"},    {31'd0, o_sram_wr},    32'd0);
        chk({tag, ".sram_size"},  {30'd0, o_sram_size},  32'd0);
        chk({tag, ".sram_addr"},  o_sram_addr,           32'd0);
        chk({tag, ".sram_wdata"}, o_sram_wdata,          32'd0);
        chk({tag, ".sram_wstrb"}, {28'd0, o_sram_wstrb}, 32'd0);
    endtask

    // Present a request for one cycle; the DUT is expected to be in IDLE.
    task automatic accept(input logic [31:0] a, input logic we, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] sz);
        req_addr     = a;
        req_write_en = we;
        req_data     = d;
        req_strobe   = s;
        req_size     = sz;
        req_valid    = 1'b1;
        chk("accept.req_ready", {31'd0, o_req_ready}, 32'd1);
        tick();
        req_valid    = 1'b0;
    endtask

    // One bus cycle with addr_ok and data_ok together.
    task automatic bus_both(input logic [31:0] rd);
        sram_addr_ok = 1'b1;
        sram_data_ok = 1'b1;
        sram_rdata   = rd;
        tick();
        sram_addr_ok = 1'b0;
        sram_data_ok = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        sel          = 1'b0;
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_write_en = 1'b0;
        req_data     = '0;
        req_strobe   = '0;
        req_size     = '0;
        resp_ready   = 1'b0;
        sram_addr_ok = 1'b0;
        sram_data_ok = 1'b0;
        sram_rdata   = '0;

        #2;
        check_reset_outputs("rst");
        #10 resetn = 1'b1;
        tick();

        // word load, single-cycle bus
        accept(32'hBFD0_0000, 1'b0, 32'h0, 4'hF, 2'd2);
        chk("ld.sram_req",  {31'd0, o_sram_req}, 32'd1);
        chk("ld.sram_wr",   {31'd0, o_sram_wr},  32'd0);
        chk("ld.sram_size", {30'd0, o_sram_size}, 32'd2);
        chk("ld.sram_addr", o_sram_addr, 32'hBFD0_0000);
        bus_both(32'h1234_5678);
        resp_ready = 1'b1;
        chk("ld.resp_valid", {31'd0, o_resp_valid}, 32'd1);
        chk("ld.resp_data",  o_resp_data, 32'h1234_5678);
        chk("ld.sram_req_lo", {31'd0, o_sram_req}, 32'd0);
        tick();
        chk("ld.req_ready_t3", {31'd0, o_req_ready}, 32'd1);
        chk("ld.resp_valid_t3", {31'd0, o_resp_valid}, 32'd0);

        // byte store, no write ack
        accept(32'hBFAF_F001, 1'b1, 32'h0000_AB00, 4'b0010, 2'd0);
        chk("st.sram_req",   {31'd0, o_sram_req},   32'd1);
        chk("st.sram_wr",    {31'd0, o_sram_wr},    32'd1);
        chk("st.sram_size",  {30'd0, o_sram_size},  32'd0);
        chk("st.sram_wstrb", {28'd0, o_sram_wstrb}, 32'h2);
        chk("st.sram_wdata", o_sram_wdata, 32'h0000_AB00);
        chk("st.sram_addr",  o_sram_addr,  32'hBFAF_F001);
        bus_both(32'hFFFF_FFFF);
        chk("st.req_ready_t2",  {31'd0, o_req_ready},  32'd1);
        chk("st.resp_valid_t2", {31'd0, o_resp_valid}, 32'd0);
        chk("st.sram_req_t2",   {31'd0, o_sram_req},   32'd0);

        // addr_ok stalled 3 cycles, data_ok 4 cycles after addr_ok
        accept(32'h1000_0040, 1'b0, 32'h0, 4'hF, 2'd2);
        for (int i = 0; i < 3; i++) begin
            chk("stall.sram_req",  {31'd0, o_sram_req}, 32'd1);
            chk("stall.sram_addr", o_sram_addr, 32'h1000_0040);
            chk("stall.sram_size", {30'd0, o_sram_size}, 32'd2);
            tick();
        end
        chk("stall.sram_req4", {31'd0, o_sram_req}, 32'd1);
        sram_addr_ok = 1'b1;
        tick();
        sram_addr_ok = 1'b0;
        chk("stall.sram_req_drop", {31'd0, o_sram_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("stall.no_resp", {31'd0, o_resp_valid}, 32'd0);
            tick();
        end
        chk("stall.no_resp4", {31'd0, o_resp_valid}, 32'd0);
        sram_data_ok = 1'b1;
        sram_rdata   = 32'hCAFE_F00D;
        tick();
        sram_data_ok = 1'b0;
        chk("stall.resp_valid", {31'd0, o_resp_valid}, 32'd1);
        chk("stall.resp_data",  o_resp_data, 32'hCAFE_F00D);
        tick();

        // resp backpressure with a pending new request
        resp_ready = 1'b0;
        accept(32'h2000_0000, 1'b0, 32'h0, 4'hF, 2'd2);
        bus_both(32'hA5A5_5A5A);
        req_addr     = 32'h2000_0004;
        req_write_en = 1'b0;
        req_size     = 2'd1;
        req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.resp_valid", {31'd0, o_resp_valid}, 32'd1);
            chk("bp.resp_data",  o_resp_data, 32'hA5A5_5A5A);
            chk("bp.req_ready",  {31'd0, o_req_ready}, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        chk("bp.hs_req_ready", {31'd0, o_req_ready}, 32'd0);
        tick();
        chk("bp.req_ready_after", {31'd0, o_req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("bp.next_sram_req",  {31'd0, o_sram_req}, 32'd1);
        chk("bp.next_sram_addr", o_sram_addr, 32'h2000_0004);
        chk("bp.next_sram_size", {30'd0, o_sram_size}, 32'd1);
        bus_both(32'h0000_0055);
        chk("bp.next_resp_data", o_resp_data, 32'h0000_0055);
        tick();

        // reset while in DATA, stray data_ok afterwards
        accept(32'h3000_0000, 1'b0, 32'h0, 4'hF, 2'd2);
        sram_addr_ok = 1'b1;
        tick();
        sram_addr_ok = 1'b0;
        chk("rstd.in_data", {31'd0, o_sram_req}, 32'd0);
        resetn = 1'b0;
        #1;
        check_reset_outputs("rstd");
        #2 resetn = 1'b1;
        tick();
        sram_data_ok = 1'b1;
        sram_rdata   = 32'hDEAD_DEAD;
        tick();
        sram_data_ok = 1'b0;
        chk("rstd.stray_req_ready",  {31'd0, o_req_ready},  32'd1);
        chk("rstd.stray_resp_valid", {31'd0, o_resp_valid}, 32'd0);
        chk("rstd.stray_resp_data",  o_resp_data, 32'd0);
        accept(32'h3000_0008, 1'b0, 32'h0, 4'hF, 2'd2);
        chk("rstd.next_sram_addr", o_sram_addr, 32'h3000_0008);
        bus_both(32'h0BAD_BEEF);
        chk("rstd.next_resp_valid", {31'd0, o_resp_valid}, 32'd1);
        chk("rstd.next_resp_data",  o_resp_data, 32'h0BAD_BEEF);
        tick();

        // WRITE_ACK = 1 instance: load to make resp nonzero, store ack, size 3 load
        sel = 1'b1;
        #1;
        accept(32'h4000_0020, 1'b0, 32'h0, 4'hF, 2'd2);
        bus_both(32'h1111_1111);
        chk("wa.pre_resp_data", o_resp_data, 32'h1111_1111);
        tick();
        accept(32'h4000_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 2'd2);
        chk("wa.st_sram_wr", {31'd0, o_sram_wr}, 32'd1);
        bus_both(32'h9999_9999);
        chk("wa.ack_valid", {31'd0, o_resp_valid}, 32'd1);
        chk("wa.ack_data",  o_resp_data, 32'd0);
        tick();
        chk("wa.one_beat", {31'd0, o_resp_valid}, 32'd0);
        accept(32'h4000_0010, 1'b0, 32'h0, 4'hF, 2'd3);
        chk("wa.sz3_sram_size", {30'd0, o_sram_size}, 32'd2);
        chk("wa.sz3_sram_req",  {31'd0, o_sram_req},  32'd1);
        bus_both(32'h7777_7777);
        chk("wa.sz3_resp_data", o_resp_data, 32'h7777_7777);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
